// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave with a fixed number of wait states.
// Optional: define DMEM_MISALIGN_ERR_EN to flag misaligned half/word accesses.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dmem_req,
   input  logic        dmem_wr_en,
   input  logic [1:0]  dmem_size,
   input  logic        dmem_zero_extend,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wr_data,
   output logic [31:0] dmem_rd_data,
   output logic        dmem_ready,
   output logic        dmem_err
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_RSVD = 2'd3;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q;
   logic          wr_en_q;
   logic [1:0]    size_q;
   logic          zx_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rd_q;
   logic          err_q;

   logic [31:0]   mem [DEPTH_WORDS];

   logic [31:0]   ea;
   logic [31:0]   off;
   logic          align_err;
   logic          mis_err;
   logic          range_err;
   logic          acc_err;
   logic          acc_edge;
   logic [AW-1:0] idx;
   logic [31:0]   word;
   logic [7:0]    ld_b;
   logic [15:0]   ld_h;
   logic [3:0]    be;
   logic [31:0]   wlanes;
   logic [31:0]   ld_data;

   // Effective address has the sub-size bits cleared for half/word accesses.
   always_comb begin
      ea        = addr_q;
      align_err = 1'b0;
      case (size_q)
         SZ_HALF: begin
            ea[0]     = 1'b0;
            align_err = addr_q[0];
         end
         SZ_WORD: begin
            ea[1:0]   = 2'b00;
            align_err = |addr_q[1:0];
         end
         default: ;
      endcase
   end

`ifdef DMEM_MISALIGN_ERR_EN
   assign mis_err = align_err;
`else
   assign mis_err = 1'b0;
`endif

   assign off       = ea - BASE_ADDR;
   assign range_err = (ea < BASE_ADDR) || ({2'b00, off[31:2]} >= DEPTH_L);
   assign acc_err   = range_err || mis_err || (size_q == SZ_RSVD);
   assign idx       = off[AW+1:2];
   assign word      = mem[idx];
   assign acc_edge  = (state_q == BUSY) && (cnt_q == 4'd0);
   assign ld_b      = 8'(word >> {ea[1:0], 3'b000});
   assign ld_h      = 16'(word >> {ea[1], 4'b0000});

   always_comb begin
      be      = 4'h0;
      wlanes  = '0;
      ld_data = '0;
      case (size_q)
         SZ_BYTE: begin
            be      = 4'b0001 << ea[1:0];
            wlanes  = {4{wdata_q[7:0]}};
            ld_data = zx_q ? {24'h0, ld_b} : {{24{ld_b[7]}}, ld_b};
         end
         SZ_HALF: begin
            be      = 4'b0011 << {ea[1], 1'b0};
            wlanes  = {2{wdata_q[15:0]}};
            ld_data = zx_q ? {16'h0, ld_h} : {{16{ld_h[15]}}, ld_h};
         end
         SZ_WORD: begin
            be      = 4'hF;
            wlanes  = wdata_q;
            ld_data = word;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (dmem_req) state_d = BUSY;
         BUSY:    if (cnt_q == 4'd0) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_en_q <= 1'b0;
         size_q  <= '0;
         zx_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && dmem_req) begin
            wr_en_q <= dmem_wr_en;
            size_q  <= dmem_size;
            zx_q    <= dmem_zero_extend;
            addr_q  <= dmem_addr;
            wdata_q <= dmem_wr_data;
            cnt_q   <= WAIT_L;
         end else if (state_q == BUSY && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
         end
         // Response data lives only for the single RESP cycle.
         if (acc_edge) begin
            err_q <= acc_err;
            rd_q  <= (acc_err || wr_en_q) ? '0 : ld_data;
         end else if (state_q == RESP) begin
            err_q <= 1'b0;
            rd_q  <= '0;
         end
      end
   end

   // Storage has no reset; a reset at the access edge suppresses the write.
   always_ff @(posedge clk) begin
      if (!reset && acc_edge && wr_en_q && !acc_err) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
         end
      end
   end

   assign dmem_ready   = (state_q == RESP);
   assign dmem_err     = err_q;
   assign dmem_rd_data = rd_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder, one instance
// with one wait state and one with three for the reset-abort case.
module tb_dmem_responder;

   localparam int unsigned DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst1, rst3, req1, req3;
   logic        wr_en, zx;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic [31:0] rd1, rd3;
   logic        rdy1, rdy3, err1, err3;

   always #5 clk = ~clk;

   dmem_responder #(
      .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1), .BASE_ADDR(BASE)
   ) u_dut1 (
      .clk(clk), .reset(rst1), .dmem_req(req1), .dmem_wr_en(wr_en),
      .dmem_size(size), .dmem_zero_extend(zx), .dmem_addr(addr),
      .dmem_wr_data(wdata), .dmem_rd_data(rd1), .dmem_ready(rdy1),
      .dmem_err(err1)
   );

   dmem_responder #(
      .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3), .BASE_ADDR(BASE)
   ) u_dut3 (
      .clk(clk), .reset(rst3), .dmem_req(req3), .dmem_wr_en(wr_en),
      .dmem_size(size), .dmem_zero_extend(zx), .dmem_addr(addr),
      .dmem_wr_data(wdata), .dmem_rd_data(rd3), .dmem_ready(rdy3),
      .dmem_err(err3)
   );

   typedef struct packed {
      logic        err;
      logic [31:0] rd;
      logic [31:0] lat;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_pass = 0;
   logic [31:0] mdl [DEPTH];
   bit          seen3;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic acc(input bit s3, input string tag, input logic w,
                      input logic [1:0] sz, input logic z,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic e_err, input logic [31:0] e_rd);
      exp_t e;
      int   k;
      bit   seen;
      sb.push_back('{err: e_err, rd: e_rd, lat: (s3 ? 32'd4 : 32'd2)});
      @(negedge clk);
      wr_en = w;
      size  = sz;
      zx    = z;
      addr  = a;
      wdata = d;
      if (s3) req3 = 1'b1;
      else    req1 = 1'b1;
      seen = 1'b0;
      k    = 0;
      while (!seen && k < 20) begin
         @(posedge clk);
         #1;
         k++;
         seen = s3 ? rdy3 : rdy1;
      end
      req1 = 1'b0;
      req3 = 1'b0;
      e = sb.pop_front();
      check({tag, " ready"}, {31'd0, seen}, 32'd1);
      if (!seen) return;
      check({tag, " lat"}, 32'(k - 1), e.lat);
      check({tag, " err"}, {31'd0, (s3 ? err3 : err1)}, {31'd0, e.err});
      check({tag, " rd"}, (s3 ? rd3 : rd1), e.rd);
      @(posedge clk);
      #1;
      if (s3) check({tag, " idle"}, rd3 | {30'd0, rdy3, err3}, 32'd0);
      else    check({tag, " idle"}, rd1 | {30'd0, rdy1, err1}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst1  = 1'b1;
      rst3  = 1'b1;
      req1  = 1'b0;
      req3  = 1'b0;
      wr_en = 1'b0;
      zx    = 1'b0;
      size  = 2'd0;
      addr  = '0;
      wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst dut1", rd1 | {30'd0, rdy1, err1}, 32'd0);
      check("rst dut3", rd3 | {30'd0, rdy3, err3}, 32'd0);
      @(negedge clk);
      rst1 = 1'b0;
      rst3 = 1'b0;

      for (int i = 1; i < DEPTH; i++) begin
         mdl[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0102_0304);
         acc(0, $sformatf("init%0d", i), 1, 2'd2, 0,
             BASE + 32'(4 * i), mdl[i], 0, 32'd0);
      end

      acc(0, "st w", 1, 2'd2, 0, 32'h1000, 32'hDEAD_BEEF, 0, 32'd0);
      acc(0, "ld w", 0, 2'd2, 0, 32'h1000, 32'd0, 0, 32'hDEAD_BEEF);
      acc(0, "st b", 1, 2'd0, 0, 32'h1001, 32'hCCCC_CC80, 0, 32'd0);
      acc(0, "ld b sx", 0, 2'd0, 0, 32'h1001, 32'd0, 0, 32'hFFFF_FF80);
      acc(0, "ld b zx", 0, 2'd0, 1, 32'h1001, 32'd0, 0, 32'h0000_0080);
      acc(0, "ld w2", 0, 2'd2, 0, 32'h1000, 32'd0, 0, 32'hDEAD_80EF);
      acc(0, "ld h sx", 0, 2'd1, 0, 32'h1002, 32'd0, 0, 32'hFFFF_DEAD);
      acc(0, "ld h zx", 0, 2'd1, 1, 32'h1002, 32'd0, 0, 32'h0000_DEAD);
      acc(0, "st h", 1, 2'd1, 0, 32'h1002, 32'hFFFF_1234, 0, 32'd0);
      acc(0, "ld w3", 0, 2'd2, 1, 32'h1000, 32'd0, 0, 32'h1234_80EF);
      acc(0, "ld b3", 0, 2'd0, 1, 32'h1003, 32'd0, 0, 32'h0000_0012);
      acc(0, "ld h0", 0, 2'd1, 0, 32'h1000, 32'd0, 0, 32'hFFFF_80EF);
      mdl[0] = 32'h1234_80EF;

      acc(0, "ld lo", 0, 2'd2, 0, 32'h0FFC, 32'd0, 1, 32'd0);
      acc(0, "ld hi", 0, 2'd2, 0, BASE + 32'(4 * DEPTH), 32'd0, 1, 32'd0);
      acc(0, "st lo", 1, 2'd2, 0, 32'h0FFC, 32'hFFFF_FFFF, 1, 32'd0);
      acc(0, "st hi", 1, 2'd2, 0, BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF,
          1, 32'd0);
      acc(0, "st rsvd", 1, 2'd3, 0, 32'h1000, 32'hFFFF_FFFF, 1, 32'd0);
      acc(0, "ld rsvd", 0, 2'd3, 0, 32'h1000, 32'd0, 1, 32'd0);

`ifdef DMEM_MISALIGN_ERR_EN
      acc(0, "mis w", 0, 2'd2, 0, 32'h1002, 32'd0, 1, 32'd0);
      acc(0, "mis h", 0, 2'd1, 0, 32'h1003, 32'd0, 1, 32'd0);
`else
      acc(0, "mis w", 0, 2'd2, 0, 32'h1002, 32'd0, 0, 32'h1234_80EF);
      acc(0, "mis h", 0, 2'd1, 0, 32'h1003, 32'd0, 0, 32'h0000_1234);
`endif

      for (int i = 0; i < DEPTH; i++) begin
         acc(0, $sformatf("sweep%0d", i), 0, 2'd2, 0,
             BASE + 32'(4 * i), 32'd0, 0, mdl[i]);
      end

      acc(1, "w3 st", 1, 2'd2, 0, 32'h1004, 32'hAABB_CCDD, 0, 32'd0);
      acc(1, "w3 ld", 0, 2'd2, 0, 32'h1004, 32'd0, 0, 32'hAABB_CCDD);

      @(negedge clk);
      wr_en = 1'b1;
      size  = 2'd0;
      zx    = 1'b0;
      addr  = 32'h1004;
      wdata = 32'h0000_0055;
      req3  = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst3  = 1'b1;
      req3  = 1'b0;
      seen3 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (rdy3) seen3 = 1'b1;
         if (i == 0) check("abort rst", rd3 | {30'd0, rdy3, err3}, 32'd0);
         if (i == 1) rst3 = 1'b0;
      end
      check("abort no ready", {31'd0, seen3}, 32'd0);
      acc(1, "abort ld", 0, 2'd2, 0, 32'h1004, 32'd0, 0, 32'hAABB_CCDD);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit storage words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra busy cycles per access (0..15).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_1000, byte address of word 0.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port dmem_req  input  1  access request, held with all request fields until dmem_ready.
REQ-007 SHALL have port dmem_wr_en  input  1  1 = store, 0 = load.
REQ-008 SHALL have port dmem_size  input  2  mem_size_t: 0 byte, 1 half, 2 word, 3 reserved.
REQ-009 SHALL have port dmem_zero_extend  input  1  load extension: 1 zero, 0 sign.
REQ-010 SHALL have port dmem_addr  input  32  byte address.
REQ-011 SHALL have port dmem_wr_data  input  32  store data, LSB-aligned.
REQ-012 SHALL have port dmem_rd_data  output  32  load result, valid only while dmem_ready=1.
REQ-013 SHALL have port dmem_ready  output  1  one-cycle completion pulse.
REQ-014 SHALL have port dmem_err  output  1  access error, valid only while dmem_ready=1.

Function
REQ-015 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE.
REQ-016 SHALL in IDLE on an edge with dmem_req=1 register wr_en, size, zero_extend, addr, wr_data, load a counter with WAIT_CYCLES, and go to BUSY.
REQ-017 SHALL in BUSY decrement the counter each cycle; at the edge where the counter is 0, perform the access and go to RESP.
REQ-018 SHALL assert dmem_ready for exactly one cycle in RESP, then return to IDLE; dmem_req is ignored in BUSY and RESP.
REQ-019 SHALL give latency acceptance edge to first ready-high cycle of WAIT_CYCLES+1 cycles.
REQ-020 SHALL store little-endian: byte writes lane addr[1:0], half writes lanes {addr[1],0}..+1, word writes all lanes; other lanes unchanged.
REQ-021 SHALL on loads select the same lanes and sign- or zero-extend to 32 bits per dmem_zero_extend; word loads ignore it.
REQ-022 SHALL register dmem_rd_data at the access edge; dmem_rd_data SHALL be 0 for stores and erroring accesses.
REQ-023 SHALL flag out-of-range (addr-BASE_ADDR underflows or word index >= DEPTH_WORDS) and size=3 as errors: dmem_err=1, no write, rd_data 0.
REQ-024 SHALL hold dmem_ready, dmem_err and dmem_rd_data at 0 outside RESP.

Reset
REQ-025 SHALL on reset=1 force state IDLE, counter 0, dmem_ready 0, dmem_err 0, dmem_rd_data 0, and clear all captured request registers.
REQ-026 SHALL abandon an in-flight access if reset is high at or before its access edge: no write committed, no ready pulse.
REQ-027 SHALL NOT reset storage contents.

Configuration
REQ-028 SHALL with DMEM_MISALIGN_ERR_EN defined treat half with addr[0]=1 or word with addr[1:0]!=0 as an error per REQ-023.
REQ-029 SHALL without DMEM_MISALIGN_ERR_EN force addr[0]=0 for half and addr[1:0]=0 for word accesses and complete without error.

Verification
REQ-030 SHALL cover: WAIT_CYCLES=1, store word 0xDEADBEEF @0x1000 then load word @0x1000 -> ready 2 cycles after each accept, rd_data 0xDEADBEEF, err 0.
REQ-031 SHALL cover: after REQ-030, store byte 0x80 @0x1001, load byte sign-ext @0x1001 -> 0xFFFFFF80; zero-ext -> 0x00000080; load word @0x1000 -> 0xDEAD80EF.
REQ-032 SHALL cover: load half @0x1002 sign-ext with 0xDEAD80EF stored -> 0xFFFFDEAD; store half 0x1234 @0x1002 then load word -> 0x123480EF.
REQ-033 SHALL cover: load @0x0FFC and @BASE_ADDR+4*DEPTH_WORDS -> err 1, rd_data 0; store there leaves all words unchanged.
REQ-034 SHALL cover: load word @0x1002 -> err 1 with DMEM_MISALIGN_ERR_EN, rd_data 0x123480EF and err 0 without.
REQ-035 SHALL cover: WAIT_CYCLES=3, accept store 0x55 @0x1004, reset high in the second BUSY cycle -> no ready pulse, subsequent load @0x1004 returns prior contents.
